// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage -- instruction-fetch stage of the Riscv151 pipeline.
//
// Holds the fetch PC (pc_req), drives the synchronous-read BIOS and IMEM
// instruction ports and presents PC_IF / instruction_IF to decode under a
// valid/ready handshake. Execute redirects take effect on the next cycle;
// only the squashed wrong-path slot is lost.
//
// Optional feature macro: FETCH_ADDR_CHECK_EN
//   defined   : unmapped/misaligned fetch addresses raise fetch_fault and park
//               the stage in FAULT until a redirect arrives.
//   undefined : no fault detection, fetch_fault tied 0, redirect_pc[1:0]
//               forced to 0, unmapped addresses present NOP_INSTR as valid.
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous reset, active-low
//   ready_ID       in   1   decode accepts the current instruction
//   redirect_valid in   1   execute requests a PC redirect
//   redirect_pc    in  32   redirect target
//   bios_addra     out 12   BIOS word address (fetch_addr[13:2])
//   bios_douta     in  32   BIOS read data, 1-cycle latency
//   imem_addrb     out 14   IMEM word address (fetch_addr[15:2])
//   imem_doutb     in  32   IMEM read data, 1-cycle latency
//   PC_IF          out 32   address of instruction_IF
//   instruction_IF out 32   fetched instruction (NOP_INSTR when not valid)
//   valid_IF       out  1   instruction_IF is real and not squashed
//   fetch_fault    out  1   bad fetch address
//   fetch_count    out 32   instructions accepted by decode
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h4000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready_ID,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [11:0] bios_addra,
    input  logic [31:0] bios_douta,
    output logic [13:0] imem_addrb,
    input  logic [31:0] imem_doutb,
    output logic [31:0] PC_IF,
    output logic [31:0] instruction_IF,
    output logic        valid_IF,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_req_q, pc_req_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        sel_bios;
    logic        sel_imem;
    logic        bad;
    logic        advance;
    logic [31:0] redirect_target;
    logic [31:0] fetch_addr;

    // Memory data arriving this cycle belongs to pc_req_q, so the source
    // decode is done on the registered PC, not on fetch_addr.
    assign sel_bios = (pc_req_q[31:28] == 4'h4);
    assign sel_imem = (pc_req_q[31:28] == 4'h1);

`ifdef FETCH_ADDR_CHECK_EN
    assign bad             = ~(sel_bios | sel_imem) | (pc_req_q[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
`else
    assign bad             = 1'b0;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign valid_IF = (state_q == RUN) & ~redirect_valid & ~bad;
    assign advance  = valid_IF & ready_ID;

    // A stall simply re-requests pc_req_q; the synchronous memories then
    // return the same word again, so no instruction hold register is needed.
    always_comb begin
        fetch_addr = pc_req_q;
        if (state_q == BOOT) begin
            fetch_addr = RESET_PC;
        end else if (redirect_valid) begin
            fetch_addr = redirect_target;
        end else if (advance) begin
            fetch_addr = pc_req_q + 32'd4;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_req_d      = fetch_addr;
        fetch_count_d = fetch_count_q + {31'd0, advance};
        unique case (state_q)
            BOOT:  state_d = RUN;
            RUN:   if (bad && !redirect_valid) state_d = FAULT;
            FAULT: if (redirect_valid) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BOOT;
            pc_req_q      <= RESET_PC;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_req_q      <= pc_req_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        instruction_IF = NOP_INSTR;
        if (valid_IF) begin
            if (sel_bios) begin
                instruction_IF = bios_douta;
            end else if (sel_imem) begin
                instruction_IF = imem_doutb;
            end
        end
    end

`ifdef FETCH_ADDR_CHECK_EN
    // Asserted in the first bad cycle (still RUN) and held through FAULT.
    assign fetch_fault = (state_q == FAULT) |
                         ((state_q == RUN) & bad & ~redirect_valid);
`else
    assign fetch_fault = 1'b0;
`endif

    assign bios_addra  = fetch_addr[13:2];
    assign imem_addrb  = fetch_addr[15:2];
    assign PC_IF       = pc_req_q;
    assign fetch_count = fetch_count_q;

endmodule
